// File: rtl/turn_sched.sv
// Turn scheduler and token mover for the chicken-race board game.
// Walks the active token on matching flips, hops over occupied tiles and declares a lap winner.
module turn_sched #(
    parameter int TILES    = 24,
    parameter int LAPS     = 2,
    parameter int STEP_GAP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] num_pl,
    input  logic       flip_vld,
    input  logic       flip_match,
    output logic [1:0] turn,
    output logic [4:0] pos0,
    output logic [4:0] pos1,
    output logic [4:0] pos2,
    output logic [4:0] pos3,
    output logic [1:0] lap0,
    output logic [1:0] lap1,
    output logic [1:0] lap2,
    output logic [1:0] lap3,
    output logic       step_pulse,
    output logic       busy,
    output logic       winner_vld,
    output logic [1:0] winner
);
    typedef enum logic [2:0] {IDLE, WAIT, STEP, GAP, DONE} state_t;

    localparam logic [4:0]  LAST     = 5'(TILES - 1);
    localparam logic [1:0]  LAPS_L   = 2'(LAPS);
    localparam logic [4:0]  SEG2     = 5'(TILES / 2);
    localparam logic [4:0]  SEG3     = 5'(TILES / 3);
    localparam logic [4:0]  SEG3_2   = 5'(2 * (TILES / 3));
    localparam logic [4:0]  SEG4     = 5'(TILES / 4);
    localparam logic [4:0]  SEG4_2   = 5'(2 * (TILES / 4));
    localparam logic [4:0]  SEG4_3   = 5'(3 * (TILES / 4));
    localparam logic [15:0] GAP_LOAD = 16'((STEP_GAP > 1) ? (STEP_GAP - 2) : 0);
    localparam logic        NO_GAP   = (STEP_GAP == 1);

    state_t      state;
    logic [2:0]  np_r;
    logic [4:0]  pos [4];
    logic [1:0]  lap [4];
    logic [15:0] gap_cnt;

    logic [4:0]  cur_pos;
    logic [4:0]  nxt_pos;
    logic        wrap;
    logic        occupied;
    logic        won;
    logic        do_step;

    assign pos0 = pos[0];
    assign pos1 = pos[1];
    assign pos2 = pos[2];
    assign pos3 = pos[3];
    assign lap0 = lap[0];
    assign lap1 = lap[1];
    assign lap2 = lap[2];
    assign lap3 = lap[3];

    // In STEP, cur_pos is the tile just landed on, so occupancy and win are judged there.
    always_comb begin
        cur_pos  = pos[turn];
        wrap     = (cur_pos == LAST);
        nxt_pos  = wrap ? 5'd0 : cur_pos + 5'd1;
        won      = (lap[turn] == LAPS_L);
        occupied = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if ((2'(k) != turn) && (3'(k) < np_r) && (pos[k] == cur_pos))
                occupied = 1'b1;
        end
        do_step = ((state == WAIT) && flip_vld && flip_match) ||
                  ((state == STEP) && !won && occupied && NO_GAP) ||
                  ((state == GAP) && (gap_cnt == 16'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            np_r       <= 3'd0;
            turn       <= 2'd0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            winner_vld <= 1'b0;
            winner     <= 2'd0;
            gap_cnt    <= 16'd0;
            for (int k = 0; k < 4; k++) begin
                pos[k] <= 5'd0;
                lap[k] <= 2'd0;
            end
        end else if (start) begin
            state      <= WAIT;
            turn       <= 2'd0;
            step_pulse <= 1'b0;
            busy       <= 1'b0;
            winner_vld <= 1'b0;
            winner     <= 2'd0;
            gap_cnt    <= 16'd0;
            pos[0]     <= 5'd0;
            for (int k = 0; k < 4; k++) lap[k] <= 2'd0;
            case (num_pl)
                2'd0: begin
                    np_r <= 3'd2; pos[1] <= SEG2; pos[2] <= 5'd0;   pos[3] <= 5'd0;
                end
                2'd1: begin
                    np_r <= 3'd3; pos[1] <= SEG3; pos[2] <= SEG3_2; pos[3] <= 5'd0;
                end
                default: begin
                    np_r <= 3'd4; pos[1] <= SEG4; pos[2] <= SEG4_2; pos[3] <= SEG4_3;
                end
            endcase
        end else begin
            step_pulse <= 1'b0;
            if (do_step) begin
                pos[turn]  <= nxt_pos;
                if (wrap && !won) lap[turn] <= lap[turn] + 2'd1;
                step_pulse <= 1'b1;
                busy       <= 1'b1;
                state      <= STEP;
            end else begin
                case (state)
                    WAIT: if (flip_vld) turn <= (3'(turn) == np_r - 3'd1) ? 2'd0 : turn + 2'd1;
                    STEP: begin
                        if (won) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            winner_vld <= 1'b1;
                            winner     <= turn;
                        end else if (occupied) begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end else begin
                            state <= WAIT;
                            busy  <= 1'b0;
                        end
                    end
                    GAP: gap_cnt <= gap_cnt - 16'd1;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_turn_sched.sv
// Bench for turn_sched: directed scenarios followed by randomized play,
// all checked against a hop-planning reference model.
module tb_turn_sched;
    localparam int TILES = 24;
    localparam int LAPS  = 1;
    localparam int G     = 4;

    logic       clk = 1'b0;
    logic       rst, start, flip_vld, flip_match;
    logic [1:0] num_pl;
    logic [1:0] turn, lap0, lap1, lap2, lap3, winner;
    logic [4:0] pos0, pos1, pos2, pos3;
    logic       step_pulse, busy, winner_vld;

    turn_sched #(.TILES(TILES), .LAPS(LAPS), .STEP_GAP(G)) dut (
        .clk(clk), .rst(rst), .start(start), .num_pl(num_pl),
        .flip_vld(flip_vld), .flip_match(flip_match), .turn(turn),
        .pos0(pos0), .pos1(pos1), .pos2(pos2), .pos3(pos3),
        .lap0(lap0), .lap1(lap1), .lap2(lap2), .lap3(lap3),
        .step_pulse(step_pulse), .busy(busy),
        .winner_vld(winner_vld), .winner(winner)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 waiting for flips, 2 hop in flight, 3 game over.
    int m_pos [4];
    int m_lap [4];
    int m_turn, m_np, m_mode, m_winv, m_winner, m_busy, m_sp;
    int steps_left, next_c, tail, win_pend;
    int cyc = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        n_vec++;
        assert (obs === 8'(exp)) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("turn", {6'd0, turn}, m_turn);
        chk("pos0", {3'd0, pos0}, m_pos[0]);
        chk("pos1", {3'd0, pos1}, m_pos[1]);
        chk("pos2", {3'd0, pos2}, m_pos[2]);
        chk("pos3", {3'd0, pos3}, m_pos[3]);
        chk("lap0", {6'd0, lap0}, m_lap[0]);
        chk("lap1", {6'd0, lap1}, m_lap[1]);
        chk("lap2", {6'd0, lap2}, m_lap[2]);
        chk("lap3", {6'd0, lap3}, m_lap[3]);
        chk("step_pulse", {7'd0, step_pulse}, m_sp);
        chk("busy", {7'd0, busy}, m_busy);
        chk("winner_vld", {7'd0, winner_vld}, m_winv);
        chk("winner", {6'd0, winner}, m_winner);
    endtask

    function automatic bit others_on(input int p);
        for (int j = 0; j < m_np; j++)
            if (j != m_turn && m_pos[j] == p) return 1'b1;
        return 1'b0;
    endfunction

    // Work out the whole hop up front: how many single-tile moves and whether it wins.
    task automatic plan_hop();
        int p, l;
        p = m_pos[m_turn];
        l = m_lap[m_turn];
        steps_left = 0;
        win_pend   = 0;
        forever begin
            p = (p + 1) % TILES;
            if (p == 0) l++;
            steps_left++;
            if (l >= LAPS) begin win_pend = 1; break; end
            if (!others_on(p)) break;
        end
    endtask

    task automatic take_step();
        int p;
        p = (m_pos[m_turn] + 1) % TILES;
        if (p == 0 && m_lap[m_turn] < LAPS) m_lap[m_turn]++;
        m_pos[m_turn] = p;
        m_sp   = 1;
        m_busy = 1;
        steps_left--;
        next_c = cyc + G;
        if (steps_left == 0) tail = 1;
    endtask

    task automatic model_step(input logic s, input logic [1:0] n, input logic fv,
                              input logic fm, input logic r);
        m_sp = 0;
        if (r) begin
            for (int k = 0; k < 4; k++) begin m_pos[k] = 0; m_lap[k] = 0; end
            m_turn = 0; m_np = 0; m_mode = 0; m_winv = 0; m_winner = 0; m_busy = 0;
            steps_left = 0; tail = 0; win_pend = 0;
        end else if (s) begin
            m_np = (n == 2'd0) ? 2 : (n == 2'd1) ? 3 : 4;
            for (int k = 0; k < 4; k++) begin
                m_pos[k] = (k < m_np) ? k * (TILES / m_np) : 0;
                m_lap[k] = 0;
            end
            m_turn = 0; m_mode = 1; m_winv = 0; m_winner = 0; m_busy = 0;
            steps_left = 0; tail = 0; win_pend = 0;
        end else if (m_mode == 2) begin
            if (tail != 0) begin
                tail   = 0;
                m_busy = 0;
                if (win_pend != 0) begin
                    m_mode = 3; m_winv = 1; m_winner = m_turn;
                end else begin
                    m_mode = 1;
                end
            end else if (cyc == next_c) begin
                take_step();
            end
        end else if (m_mode == 1 && fv) begin
            if (!fm) begin
                m_turn = (m_turn + 1) % m_np;
            end else begin
                plan_hop();
                m_mode = 2;
                take_step();
            end
        end
        cyc++;
    endtask

    task automatic tick(input logic s, input logic [1:0] n, input logic fv,
                        input logic fm, input logic r);
        start = s; num_pl = n; flip_vld = fv; flip_match = fm; rst = r;
        model_step(s, n, fv, fm, r);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic match_drain();
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; num_pl = 2'd0; flip_vld = 1'b0; flip_match = 1'b0;
        @(posedge clk);
        #1;

        // Reset, then flips with no game loaded
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("idle_busy", {7'd0, busy}, 0);
        chk("idle_pos0", {3'd0, pos0}, 0);

        // Load three players and make one match
        tick(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("ld_pos1", {3'd0, pos1}, 8);
        chk("ld_pos2", {3'd0, pos2}, 16);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("m1_pos0", {3'd0, pos0}, 1);
        chk("m1_pulse", {7'd0, step_pulse}, 1);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("m1_busy_low", {7'd0, busy}, 0);
        chk("m1_turn", {6'd0, turn}, 0);

        // Miss rotation with three players: 1, 2, 0, 1
        tick(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0); chk("rot1", {6'd0, turn}, 1);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0); chk("rot2", {6'd0, turn}, 2);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0); chk("rot3", {6'd0, turn}, 0);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0); chk("rot4", {6'd0, turn}, 1);

        // Hop over player 1 at tile 6, with a flip arriving mid-hop
        tick(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) match_drain();
        chk("hop_pre", {3'd0, pos0}, 5);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("hop_s1", {3'd0, pos0}, 6);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("hop_busy", {7'd0, busy}, 1);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("hop_nopulse", {7'd0, step_pulse}, 0);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("hop_s2", {3'd0, pos0}, 7);
        chk("hop_s2_pulse", {7'd0, step_pulse}, 1);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("hop_done", {7'd0, busy}, 0);

        // Two players: player 1 runs from 12 around to 0 and wins
        tick(1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) match_drain();
        chk("win_pre", {3'd0, pos1}, 23);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        chk("win_pos1", {3'd0, pos1}, 0);
        chk("win_lap1", {6'd0, lap1}, 1);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("win_vld", {7'd0, winner_vld}, 1);
        chk("win_who", {6'd0, winner}, 1);
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("done_frozen", {3'd0, pos1}, 0);

        // Start while DONE
        tick(1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
        chk("restart_vld", {7'd0, winner_vld}, 0);
        chk("restart_pos3", {3'd0, pos3}, 18);

        // Reset during GAP
        for (int i = 0; i < 5; i++) match_drain();
        tick(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_gap_busy", {7'd0, busy}, 0);
        chk("rst_gap_pos0", {3'd0, pos0}, 0);

        // Randomized play
        tick(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 599) == 0));
            if (m_mode == 0 || m_mode == 3) begin
                if ($urandom_range(0, 9) == 0)
                    tick(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
